// File: rtl/mem_stage.sv
// EX/MEM pipeline register, data-memory access FSM and MEM/WB register for the rv32i pipeline.
// Word loads and stores go out on a req/gnt/rvalid bus; the front of the pipeline stalls while an access is outstanding.
module mem_stage #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            RegWriteE,
   input  logic            MemWriteE,
   input  logic [1:0]      ResultSrcE,
   input  logic [4:0]      RdE,
   input  logic [XLEN-1:0] ALUResultE,
   input  logic [XLEN-1:0] WriteDataE,
   input  logic [XLEN-1:0] PCPlus4E,
   input  logic            IDEX_valid,
   output logic [XLEN-1:0] ALUResultM,
   output logic [4:0]      RdM,
   output logic            RegWriteM,
   output logic            StallM,
   output logic            MisalignM,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_gnt,
   input  logic            dmem_rvalid,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            RegWriteW,
   output logic [1:0]      ResultSrcW,
   output logic [4:0]      RdW,
   output logic [XLEN-1:0] ALUResultW,
   output logic [XLEN-1:0] ReadDataW,
   output logic [XLEN-1:0] PCPlus4W,
   output logic            EXMEM_valid,
   output logic            MEMWB_valid
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

   state_e state_q, state_d;

   logic            exm_valid_q, exm_valid_d;
   logic            exm_regwrite_q, exm_regwrite_d;
   logic            exm_memwrite_q, exm_memwrite_d;
   logic [1:0]      exm_resultsrc_q, exm_resultsrc_d;
   logic [4:0]      exm_rd_q, exm_rd_d;
   logic [XLEN-1:0] exm_alu_q, exm_alu_d;
   logic [XLEN-1:0] exm_wdata_q, exm_wdata_d;
   logic [XLEN-1:0] exm_pc4_q, exm_pc4_d;

   logic            wb_valid_q, wb_valid_d;
   logic            wb_regwrite_q, wb_regwrite_d;
   logic [1:0]      wb_resultsrc_q, wb_resultsrc_d;
   logic [4:0]      wb_rd_q, wb_rd_d;
   logic [XLEN-1:0] wb_alu_q, wb_alu_d;
   logic [XLEN-1:0] wb_rdata_q, wb_rdata_d;
   logic [XLEN-1:0] wb_pc4_q, wb_pc4_d;

   logic is_load, is_store, misalign, memop, complete;

   assign is_load  = exm_valid_q & (exm_resultsrc_q == 2'b01);
   assign is_store = exm_valid_q & exm_memwrite_q;
   assign misalign = (is_load | is_store) & (exm_alu_q[1:0] != 2'b00);
   assign memop    = (is_load | is_store) & ~misalign;

   // Bus FSM: complete marks the cycle an aligned memop retires into MEM/WB
   always_comb begin
      state_d  = state_q;
      dmem_req = 1'b0;
      complete = 1'b0;
      case (state_q)
         IDLE: begin
            if (memop) begin
               dmem_req = 1'b1;
               if (dmem_gnt) begin
                  if (is_load) state_d = RESP;
                  else         complete = 1'b1;
               end else begin
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            dmem_req = 1'b1;
            if (dmem_gnt) begin
               if (is_load) begin
                  state_d = RESP;
               end else begin
                  complete = 1'b1;
                  state_d  = IDLE;
               end
            end
         end
         RESP: begin
            if (dmem_rvalid) begin
               complete = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign StallM    = memop & ~complete;
   assign MisalignM = misalign;

   // EX/MEM capture (holds while stalled) and MEM/WB capture (bubble while stalled)
   always_comb begin
      exm_valid_d     = exm_valid_q;
      exm_regwrite_d  = exm_regwrite_q;
      exm_memwrite_d  = exm_memwrite_q;
      exm_resultsrc_d = exm_resultsrc_q;
      exm_rd_d        = exm_rd_q;
      exm_alu_d       = exm_alu_q;
      exm_wdata_d     = exm_wdata_q;
      exm_pc4_d       = exm_pc4_q;
      wb_valid_d      = 1'b0;
      wb_regwrite_d   = 1'b0;
      wb_resultsrc_d  = wb_resultsrc_q;
      wb_rd_d         = wb_rd_q;
      wb_alu_d        = wb_alu_q;
      wb_rdata_d      = wb_rdata_q;
      wb_pc4_d        = wb_pc4_q;
      if (!StallM) begin
         exm_valid_d     = IDEX_valid;
         exm_regwrite_d  = RegWriteE;
         exm_memwrite_d  = MemWriteE;
         exm_resultsrc_d = ResultSrcE;
         exm_rd_d        = RdE;
         exm_alu_d       = ALUResultE;
         exm_wdata_d     = WriteDataE;
         exm_pc4_d       = PCPlus4E;
         wb_valid_d      = exm_valid_q & ~misalign;
         wb_regwrite_d   = exm_regwrite_q & exm_valid_q & ~misalign;
         wb_resultsrc_d  = exm_resultsrc_q;
         wb_rd_d         = exm_rd_q;
         wb_alu_d        = exm_alu_q;
         wb_pc4_d        = exm_pc4_q;
         if (is_load && complete) wb_rdata_d = dmem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= IDLE;
         exm_valid_q     <= 1'b0;
         exm_regwrite_q  <= 1'b0;
         exm_memwrite_q  <= 1'b0;
         exm_resultsrc_q <= 2'b00;
         exm_rd_q        <= 5'd0;
         exm_alu_q       <= '0;
         exm_wdata_q     <= '0;
         exm_pc4_q       <= '0;
         wb_valid_q      <= 1'b0;
         wb_regwrite_q   <= 1'b0;
         wb_resultsrc_q  <= 2'b00;
         wb_rd_q         <= 5'd0;
         wb_alu_q        <= '0;
         wb_rdata_q      <= '0;
         wb_pc4_q        <= '0;
      end else begin
         state_q         <= state_d;
         exm_valid_q     <= exm_valid_d;
         exm_regwrite_q  <= exm_regwrite_d;
         exm_memwrite_q  <= exm_memwrite_d;
         exm_resultsrc_q <= exm_resultsrc_d;
         exm_rd_q        <= exm_rd_d;
         exm_alu_q       <= exm_alu_d;
         exm_wdata_q     <= exm_wdata_d;
         exm_pc4_q       <= exm_pc4_d;
         wb_valid_q      <= wb_valid_d;
         wb_regwrite_q   <= wb_regwrite_d;
         wb_resultsrc_q  <= wb_resultsrc_d;
         wb_rd_q         <= wb_rd_d;
         wb_alu_q        <= wb_alu_d;
         wb_rdata_q      <= wb_rdata_d;
         wb_pc4_q        <= wb_pc4_d;
      end
   end

   assign ALUResultM  = exm_alu_q;
   assign RdM         = exm_rd_q;
   assign RegWriteM   = exm_regwrite_q & exm_valid_q;
   assign EXMEM_valid = exm_valid_q;
   assign dmem_we     = is_store;
   assign dmem_addr   = exm_alu_q;
   assign dmem_wdata  = exm_wdata_q;

   assign RegWriteW   = wb_regwrite_q & wb_valid_q;
   assign ResultSrcW  = wb_resultsrc_q;
   assign RdW         = wb_rd_q;
   assign ALUResultW  = wb_alu_q;
   assign ReadDataW   = wb_rdata_q;
   assign PCPlus4W    = wb_pc4_q;
   assign MEMWB_valid = wb_valid_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: inputs driven on the falling edge, retirements checked against a scoreboard queue.
module tb_mem_stage;

   localparam int unsigned XLEN = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            RegWriteE, MemWriteE, IDEX_valid;
   logic [1:0]      ResultSrcE;
   logic [4:0]      RdE;
   logic [XLEN-1:0] ALUResultE, WriteDataE, PCPlus4E;
   logic [XLEN-1:0] ALUResultM, dmem_addr, dmem_wdata, dmem_rdata;
   logic [4:0]      RdM, RdW;
   logic            RegWriteM, StallM, MisalignM, dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
   logic            RegWriteW, EXMEM_valid, MEMWB_valid;
   logic [1:0]      ResultSrcW;
   logic [XLEN-1:0] ALUResultW, ReadDataW, PCPlus4W;

   typedef struct {
      logic [4:0]  rd;
      logic        rw;
      logic [1:0]  src;
      logic [31:0] alu;
      logic [31:0] rdata;
      logic [31:0] pc4;
   } wb_t;

   wb_t sb[$];
   int  n_assert = 0;
   int  n_fail   = 0;

   mem_stage #(.XLEN(XLEN)) dut (
      .clk(clk), .rst(rst),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE), .RdE(RdE),
      .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E), .IDEX_valid(IDEX_valid),
      .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM), .StallM(StallM), .MisalignM(MisalignM),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW), .ALUResultW(ALUResultW),
      .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .EXMEM_valid(EXMEM_valid), .MEMWB_valid(MEMWB_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Pop and compare one expected retirement whenever MEM/WB holds a valid instruction
   task automatic monitor();
      wb_t e;
      if (MEMWB_valid === 1'b1) begin
         n_assert++;
         assert (sb.size() != 0)
         else begin
            n_fail++;
            $error("FAIL sb_unexpected: observed retire rd=%0d alu=0x%08h expected none", RdW, ALUResultW);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("wb_rd", 32'(RdW), 32'(e.rd));
            chk("wb_regwrite", 32'(RegWriteW), 32'(e.rw));
            chk("wb_resultsrc", 32'(ResultSrcW), 32'(e.src));
            chk("wb_alu", ALUResultW, e.alu);
            chk("wb_pc4", PCPlus4W, e.pc4);
            if (e.src == 2'b01) chk("wb_rdata", ReadDataW, e.rdata);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      monitor();
   endtask

   task automatic issue(input logic rw, input logic mw, input logic [1:0] src, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                        input logic [31:0] rdata_exp, input bit push);
      wb_t e;
      IDEX_valid = 1'b1;
      RegWriteE  = rw;
      MemWriteE  = mw;
      ResultSrcE = src;
      RdE        = rd;
      ALUResultE = alu;
      WriteDataE = wd;
      PCPlus4E   = pc4;
      if (push) begin
         e.rd = rd; e.rw = rw; e.src = src; e.alu = alu; e.rdata = rdata_exp; e.pc4 = pc4;
         sb.push_back(e);
      end
   endtask

   // Invalid slot with random payload: everything must be gated by IDEX_valid
   task automatic bubble();
      IDEX_valid = 1'b0;
      RegWriteE  = 1'($urandom);
      MemWriteE  = 1'($urandom);
      ResultSrcE = 2'($urandom);
      RdE        = 5'($urandom);
      ALUResultE = $urandom;
      WriteDataE = $urandom;
      PCPlus4E   = $urandom;
   endtask

   initial begin
      rst = 1'b0;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
      bubble();

      // Reset held with random inputs
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         issue(1'($urandom), 1'($urandom), 2'($urandom), 5'($urandom), $urandom, $urandom, $urandom, 32'h0, 1'b0);
         IDEX_valid  = 1'($urandom);
         dmem_gnt    = 1'($urandom);
         dmem_rvalid = 1'($urandom);
         dmem_rdata  = $urandom;
      end
      #1;
      chk("rst_req", 32'(dmem_req), 32'h0);
      chk("rst_stall", 32'(StallM), 32'h0);
      chk("rst_misalign", 32'(MisalignM), 32'h0);
      chk("rst_alum", ALUResultM, 32'h0);
      chk("rst_regwritem", 32'(RegWriteM), 32'h0);
      chk("rst_addr", dmem_addr, 32'h0);
      chk("rst_we", 32'(dmem_we), 32'h0);
      chk("rst_exmem_valid", 32'(EXMEM_valid), 32'h0);
      chk("rst_memwb_valid", 32'(MEMWB_valid), 32'h0);
      chk("rst_regwritew", 32'(RegWriteW), 32'h0);
      chk("rst_readdataw", ReadDataW, 32'h0);

      // Release, ADD x5 = 0x1234
      @(negedge clk);
      rst = 1'b1; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
      issue(1'b1, 1'b0, 2'b00, 5'd5, 32'h0000_1234, 32'h0, 32'h0000_0044, 32'h0, 1'b1);
      step();
      bubble();
      chk("add_rdm", 32'(RdM), 32'd5);
      chk("add_alum", ALUResultM, 32'h0000_1234);
      chk("add_regwritem", 32'(RegWriteM), 32'h1);
      chk("add_stall", 32'(StallM), 32'h0);
      step();

      // Store granted immediately
      issue(1'b0, 1'b1, 2'b00, 5'd0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0050, 32'h0, 1'b1);
      step();
      bubble();
      dmem_gnt = 1'b1;
      #1;
      chk("sw0_req", 32'(dmem_req), 32'h1);
      chk("sw0_we", 32'(dmem_we), 32'h1);
      chk("sw0_addr", dmem_addr, 32'h0000_0100);
      chk("sw0_wdata", dmem_wdata, 32'hDEAD_BEEF);
      chk("sw0_stall", 32'(StallM), 32'h0);
      step();
      dmem_gnt = 1'b0;
      #1;
      chk("sw0_req_drop", 32'(dmem_req), 32'h0);

      // Store granted after three waiting cycles
      issue(1'b0, 1'b1, 2'b00, 5'd3, 32'h0000_0200, 32'h1122_3344, 32'h0000_0060, 32'h0, 1'b1);
      step();
      bubble();
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("sw3_req", 32'(dmem_req), 32'h1);
         chk("sw3_stall", 32'(StallM), 32'h1);
         chk("sw3_addr", dmem_addr, 32'h0000_0200);
         chk("sw3_wdata", dmem_wdata, 32'h1122_3344);
         step();
         chk("sw3_bubble_valid", 32'(MEMWB_valid), 32'h0);
         chk("sw3_bubble_rw", 32'(RegWriteW), 32'h0);
      end
      dmem_gnt = 1'b1;
      #1;
      chk("sw3_gnt_req", 32'(dmem_req), 32'h1);
      chk("sw3_gnt_stall", 32'(StallM), 32'h0);
      step();
      dmem_gnt = 1'b0;

      // Load: gnt at N, rvalid at N+2
      issue(1'b1, 1'b0, 2'b01, 5'd7, 32'h0000_0300, 32'h0, 32'h0000_0070, 32'hCAFE_F00D, 1'b1);
      step();
      bubble();
      dmem_gnt = 1'b1;
      #1;
      chk("lw_req", 32'(dmem_req), 32'h1);
      chk("lw_we", 32'(dmem_we), 32'h0);
      chk("lw_addr", dmem_addr, 32'h0000_0300);
      chk("lw_stall_n", 32'(StallM), 32'h1);
      step();
      dmem_gnt = 1'b0;
      #1;
      chk("lw_resp_req", 32'(dmem_req), 32'h0);
      chk("lw_stall_n1", 32'(StallM), 32'h1);
      step();
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'hCAFE_F00D;
      #1;
      chk("lw_stall_n2", 32'(StallM), 32'h0);
      step();
      chk("lw_memwb_valid", 32'(MEMWB_valid), 32'h1);
      dmem_rdata = 32'hBAD0_BAD0;
      step();
      dmem_rvalid = 1'b0;
      chk("rvalid_idle_ignored", ReadDataW, 32'hCAFE_F00D);
      chk("rvalid_idle_stall", 32'(StallM), 32'h0);

      // Misaligned load is dropped
      issue(1'b1, 1'b0, 2'b01, 5'd9, 32'h0000_0102, 32'h0, 32'h0000_0080, 32'h0, 1'b0);
      step();
      bubble();
      dmem_gnt = 1'b1;
      #1;
      chk("mis_req", 32'(dmem_req), 32'h0);
      chk("mis_pulse", 32'(MisalignM), 32'h1);
      chk("mis_stall", 32'(StallM), 32'h0);
      step();
      dmem_gnt = 1'b0;
      chk("mis_pulse_end", 32'(MisalignM), 32'h0);
      chk("mis_memwb_valid", 32'(MEMWB_valid), 32'h0);
      chk("mis_regwritew", 32'(RegWriteW), 32'h0);

      // Back-to-back stores
      issue(1'b0, 1'b1, 2'b00, 5'd1, 32'h0000_0500, 32'hA5A5_A5A5, 32'h0000_0090, 32'h0, 1'b1);
      step();
      issue(1'b0, 1'b1, 2'b00, 5'd2, 32'h0000_0504, 32'h5A5A_5A5A, 32'h0000_0094, 32'h0, 1'b1);
      dmem_gnt = 1'b1;
      #1;
      chk("b2b_addr0", dmem_addr, 32'h0000_0500);
      chk("b2b_stall0", 32'(StallM), 32'h0);
      step();
      bubble();
      #1;
      chk("b2b_req1", 32'(dmem_req), 32'h1);
      chk("b2b_addr1", dmem_addr, 32'h0000_0504);
      chk("b2b_wdata1", dmem_wdata, 32'h5A5A_5A5A);
      step();
      dmem_gnt = 1'b0;

      // Reset while waiting for load data, then a late rvalid
      issue(1'b1, 1'b0, 2'b01, 5'd10, 32'h0000_0400, 32'h0, 32'h0000_00A0, 32'h0, 1'b0);
      step();
      bubble();
      dmem_gnt = 1'b1;
      step();
      dmem_gnt = 1'b0;
      #1;
      chk("rresp_stall", 32'(StallM), 32'h1);
      chk("rresp_req", 32'(dmem_req), 32'h0);
      #1 rst = 1'b0;
      #1;
      chk("rresp_rst_stall", 32'(StallM), 32'h0);
      chk("rresp_rst_exmem", 32'(EXMEM_valid), 32'h0);
      chk("rresp_rst_req", 32'(dmem_req), 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h0BAD_F00D;
      #1;
      chk("late_rvalid_stall", 32'(StallM), 32'h0);
      chk("late_rvalid_req", 32'(dmem_req), 32'h0);
      step();
      dmem_rvalid = 1'b0;
      chk("late_rvalid_memwb", 32'(MEMWB_valid), 32'h0);
      chk("late_rvalid_rw", 32'(RegWriteW), 32'h0);
      chk("late_rvalid_rdata", ReadDataW, 32'h0);
      step();

      chk("sb_empty", 32'(sb.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
